m32b_8b: RTL and testbench

M32B_8B -- requirements
Module: m32b_8b

---
 rtl/m32b_8b_pkg.sv | 28 ++
 rtl/m32b_8b_hold.sv | 32 +++
 rtl/m32b_8b.sv | 117 +++++++++++
 tb/tb_m32b_8b.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/m32b_8b_pkg.sv
// Shared constants, state encoding and byte-select helper for the
// 32-bit <-> 8-bit width converters (m32b_8b and m8b_32b).
package m32b_8b_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int BYTES  = 4;
  localparam int CNT_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Byte idx of a word, MSB first: idx 0 is bits [31:24].
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                   input logic [CNT_W-1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/m32b_8b_hold.sv
// One-word holding register for m32b_8b: catches a word offered while the
// serializer is mid-word and backpressures the source until it is consumed.
module m32b_8b_hold
  import m32b_8b_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              load,
  input  logic              take,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] pend_data,
  output logic              pend_v,
  output logic              ready_in
);

  // Pending flag and word; load and take are mutually exclusive because a
  // load needs ready_in=1 while a take needs pend_v=1.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      pend_v    <= 1'b0;
      pend_data <= '0;
    end else if (load) begin
      pend_v    <= 1'b1;
      pend_data <= data_in;
    end else if (take) begin
      pend_v    <= 1'b0;
    end
  end

  assign ready_in = ~pend_v;

endmodule

// File: rtl/m32b_8b.sv
// 32-bit to 8-bit serializer, MSB byte first, one byte per clk_4f cycle.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word in flight; data_out=00, valid_out=0
//   SEND  | emitting word_q; cnt_q is the next byte index, 0 = last-byte
//         | edge where a pending or bypassed word is chained in
module m32b_8b
  import m32b_8b_pkg::*;
#(
  parameter int BYTES = m32b_8b_pkg::BYTES
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] data_d;
  logic              valid_d;
  logic              transfer;
  logic              hold_load;
  logic              hold_take;
  logic [WORD_W-1:0] pend_data;
  logic              pend_v;

  assign transfer = valid_in & ready_in;

  m32b_8b_hold u_hold (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .load      (hold_load),
    .take      (hold_take),
    .data_in   (data_in),
    .pend_data (pend_data),
    .pend_v    (pend_v),
    .ready_in  (ready_in)
  );

  // State register together with the registered byte outputs.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      data_out  <= data_d;
      valid_out <= valid_d;
    end
  end

  // Next state, byte counter, current word and next output byte.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = '0;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          word_d  = data_in;
          data_d  = word_byte(data_in, 2'd0);
          valid_d = 1'b1;
          cnt_d   = 2'd1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (cnt_q != 2'd0) begin
          data_d  = word_byte(word_q, cnt_q);
          valid_d = 1'b1;
          cnt_d   = (cnt_q == LAST_IDX) ? 2'd0 : cnt_q + 2'd1;
        end else if (pend_v) begin
          word_d  = pend_data;
          data_d  = word_byte(pend_data, 2'd0);
          valid_d = 1'b1;
          cnt_d   = 2'd1;
        end else if (transfer) begin
          word_d  = data_in;
          data_d  = word_byte(data_in, 2'd0);
          valid_d = 1'b1;
          cnt_d   = 2'd1;
        end else begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding-register controls: park a word offered mid-word, release it on
  // the last-byte edge.
  always_comb begin
    hold_load = 1'b0;
    hold_take = 1'b0;
    if (state_q == SEND) begin
      hold_load = transfer && (cnt_q != 2'd0);
      hold_take = pend_v && (cnt_q == 2'd0);
    end
  end

endmodule

// File: tb/tb_m32b_8b.sv
// Directed bench for m32b_8b: reset, single word, back-to-back, stall,
// bypass on the last-byte edge, reset mid-word, reset priority, and a
// random stream reassembled by the bench and compared word by word.
module tb_m32b_8b;

  logic        clk_4f   = 1'b0;
  logic        reset    = 1'b1;
  logic [31:0] data_in  = '0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [7:0]  data_out;
  logic        valid_out;

  int errors = 0;
  int checks = 0;

  m32b_8b #(.BYTES(4)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic tick;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    tick; tick;
    reset = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out=%b expected 0", valid_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset data_out=%h expected 00", data_out); end
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset ready_in=%b expected 1", ready_in); end
    tick;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL idle valid_out=%b expected 0", valid_out); end
  endtask

  task automatic test_single;
    logic [7:0] exp_b [0:3] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    valid_in = 1'b1; data_in = 32'hA1B2C3D4;
    tick;
    valid_in = 1'b0; data_in = '0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (valid_out !== 1'b1 || data_out !== exp_b[i]) begin
        errors++; $display("FAIL single byte %0d: valid=%b data=%h expected valid=1 data=%h", i, valid_out, data_out, exp_b[i]);
      end
      checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL single ready byte %0d: ready=%b expected 1", i, ready_in); end
      tick;
    end
    checks++; if (valid_out !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL single end: valid=%b data=%h expected valid=0 data=00", valid_out, data_out);
    end
  endtask

  task automatic test_back_to_back;
    logic        vin [0:8] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] din [0:8] = '{32'h01020304, 32'h05060708, 0, 0, 0, 0, 0, 0, 0};
    logic        ev  [0:8] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0]  ed  [0:8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
    logic        er  [0:8] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int k = 0; k < 9; k++) begin
      valid_in = vin[k]; data_in = din[k];
      tick;
      checks++; if (valid_out !== ev[k] || data_out !== ed[k] || ready_in !== er[k]) begin
        errors++; $display("FAIL b2b step %0d: valid=%b data=%h ready=%b expected valid=%b data=%h ready=%b",
                           k, valid_out, data_out, ready_in, ev[k], ed[k], er[k]);
      end
    end
  endtask

  task automatic test_stall;
    logic        vin [0:12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] din [0:12] = '{32'h11223344, 32'h55667788, 32'hDEADBEEF, 32'h99AABBCC,
                                32'h99AABBCC, 32'h99AABBCC, 0, 0, 0, 0, 0, 0, 0};
    logic        ev  [0:12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0]  ed  [0:12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    logic        er  [0:12] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int k = 0; k < 13; k++) begin
      valid_in = vin[k]; data_in = din[k];
      tick;
      checks++; if (valid_out !== ev[k] || data_out !== ed[k] || ready_in !== er[k]) begin
        errors++; $display("FAIL stall step %0d: valid=%b data=%h ready=%b expected valid=%b data=%h ready=%b",
                           k, valid_out, data_out, ready_in, ev[k], ed[k], er[k]);
      end
    end
  endtask

  task automatic test_bypass;
    logic        vin [0:8] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    logic [31:0] din [0:8] = '{32'hCAFEBABE, 0, 0, 0, 32'h12345678, 0, 0, 0, 0};
    logic        ev  [0:8] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [7:0]  ed  [0:8] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    for (int k = 0; k < 9; k++) begin
      valid_in = vin[k]; data_in = din[k];
      tick;
      checks++; if (valid_out !== ev[k] || data_out !== ed[k] || ready_in !== 1'b1) begin
        errors++; $display("FAIL bypass step %0d: valid=%b data=%h ready=%b expected valid=%b data=%h ready=1",
                           k, valid_out, data_out, ready_in, ev[k], ed[k]);
      end
    end
  endtask

  task automatic test_reset_mid_word;
    logic        rst [0:6] = '{0, 0, 1, 0, 0, 0, 0};
    logic        vin [0:6] = '{1, 1, 0, 0, 0, 0, 0};
    logic [31:0] din [0:6] = '{32'hA1B2C3D4, 32'h01020304, 0, 0, 0, 0, 0};
    logic        ev  [0:6] = '{1, 1, 0, 0, 0, 0, 0};
    logic [7:0]  ed  [0:6] = '{8'hA1, 8'hB2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic        er  [0:6] = '{1, 0, 1, 1, 1, 1, 1};
    for (int k = 0; k < 7; k++) begin
      reset = rst[k]; valid_in = vin[k]; data_in = din[k];
      tick;
      checks++; if (valid_out !== ev[k] || data_out !== ed[k] || ready_in !== er[k]) begin
        errors++; $display("FAIL rst_mid step %0d: valid=%b data=%h ready=%b expected valid=%b data=%h ready=%b",
                           k, valid_out, data_out, ready_in, ev[k], ed[k], er[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_priority;
    reset = 1'b1; valid_in = 1'b1; data_in = 32'h5A5A5A5A;
    tick;
    reset = 1'b0; valid_in = 1'b0; data_in = '0;
    checks++; if (valid_out !== 1'b0 || data_out !== 8'h00 || ready_in !== 1'b1) begin
      errors++; $display("FAIL rst_prio edge: valid=%b data=%h ready=%b expected 0/00/1", valid_out, data_out, ready_in);
    end
    tick;
    checks++; if (valid_out !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL rst_prio after: valid=%b data=%h expected 0/00 (word must not be taken)", valid_out, data_out);
    end
  endtask

  task automatic test_random_stream;
    logic [31:0] sent [$];
    logic [31:0] acc = '0;
    logic [31:0] w;
    int nbytes = 0;
    int n_in   = 0;
    int n_out  = 0;
    int cyc    = 0;
    while (n_out < 16 && cyc < 400) begin
      if (n_in < 16) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = $urandom;
      end else begin
        valid_in = 1'b0;
        data_in  = '0;
      end
      if (valid_in && ready_in) begin
        sent.push_back(data_in);
        n_in++;
      end
      tick;
      cyc++;
      if (valid_out) begin
        acc = {acc[23:0], data_out};
        nbytes++;
        if (nbytes == 4) begin
          nbytes = 0;
          n_out++;
          checks++;
          if (sent.size() == 0) begin
            errors++; $display("FAIL stream word %0d: got %h with no word sent", n_out, acc);
          end else begin
            w = sent.pop_front();
            if (acc !== w) begin
              errors++; $display("FAIL stream word %0d: got %h expected %h", n_out, acc, w);
            end
          end
        end
      end
    end
    valid_in = 1'b0; data_in = '0;
    checks++; if (n_out != 16 || nbytes != 0) begin
      errors++; $display("FAIL stream count: words=%0d leftover bytes=%0d expected 16 and 0", n_out, nbytes);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_bypass;
    test_reset_mid_word;
    test_reset_priority;
    test_random_stream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
